// File: rtl/rs232_recv_pkg.sv
// Shared definitions for the FT232 serial link: 8N1 frame constants, receiver
// FSM states and the baud-accumulator width helper used by rs232_send as well.
package rs232_recv_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    // ceil(log2(clock_freq)) + 1: headroom so acc + BAUD_RATE never wraps
    function automatic int unsigned acc_width(input longint unsigned clock_freq);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 63; i++) begin
            if ((64'd1 << i) < clock_freq) begin
                w = i + 1;
            end
        end
        return w + 1;
    endfunction

endpackage

// File: rtl/rs232_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is accepted only
// when a pop frees the head slot in the same cycle.
module rs232_fifo
    import rs232_recv_pkg::*;
#(
    parameter int unsigned FIFO_LOG2 = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] rdata,
    output logic [FIFO_LOG2:0]   count,
    output logic [FIFO_LOG2:0]   count_next,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned           DEPTH   = 2 ** FIFO_LOG2;
    localparam logic [FIFO_LOG2:0]    CNT_ONE = 1;
    localparam logic [FIFO_LOG2:0]    CNT_MAX = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_LOG2-1:0]  PTR_ONE = 1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    always_comb begin
        empty      = (count == '0);
        full       = (count == CNT_MAX);
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_next = count - CNT_ONE;
        end
        rdata = mem[rd_ptr];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/rs232_recv.sv
// FT232 UART receiver: synchronises rxd, samples mid-bit with a fractional baud
// accumulator, deserialises 8N1 frames into a FWFT FIFO and drives cts_n.
module rs232_recv
    import rs232_recv_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 133000000,
    parameter int unsigned BAUD_RATE  = 12000000,
    parameter int unsigned FIFO_LOG2  = 4,
    parameter int unsigned CTS_SLACK  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rxd,
    output logic                 cts_n,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_error,
    output logic                 overrun
);

    localparam int unsigned          ACC_W     = acc_width(longint'(CLOCK_FREQ));
    localparam logic [ACC_W-1:0]     ACC_FREQ  = ACC_W'(CLOCK_FREQ);
    localparam logic [ACC_W-1:0]     ACC_BAUD  = ACC_W'(BAUD_RATE);
    localparam logic [ACC_W-1:0]     ACC_HALF  = ACC_W'(CLOCK_FREQ / 2);
    localparam int unsigned          DEPTH     = 2 ** FIFO_LOG2;
    localparam logic [FIFO_LOG2:0]   CTS_LIMIT = (FIFO_LOG2 + 1)'(DEPTH - CTS_SLACK);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);
    localparam logic [BIT_IDX_W-1:0] IDX_ONE   = 1;

    logic                 rs_meta;
    logic                 rs;

    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_sum;
    logic                 tick;

    rx_state_t            state;
    rx_state_t            state_next;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 load_acc;
    logic                 shift_en;
    logic                 byte_done;
    logic                 frame_bad;

    logic                 fifo_pop;
    logic [FIFO_LOG2:0]   fifo_count;
    logic [FIFO_LOG2:0]   fifo_count_next;
    logic                 fifo_full;
    logic                 fifo_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            rs_meta <= 1'b1;
            rs      <= 1'b1;
        end else begin
            rs_meta <= rxd;
            rs      <= rs_meta;
        end
    end

    // Remainder is carried across ticks, so bit-period rounding never accumulates
    always_comb begin
        acc_sum = acc + ACC_BAUD;
        tick    = (acc_sum >= ACC_FREQ);
    end

    always_comb begin
        state_next = state;
        load_acc   = 1'b0;
        shift_en   = 1'b0;
        byte_done  = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rs) begin
                    state_next = ST_START;
                    load_acc   = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_next = rs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rs) begin
                        byte_done  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rs) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            acc     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state <= state_next;
            if (load_acc) begin
                acc <= ACC_HALF;
            end else if (tick) begin
                acc <= acc_sum - ACC_FREQ;
            end else begin
                acc <= acc_sum;
            end
            if (shift_en) begin
                bit_idx <= bit_idx + IDX_ONE;
                shreg   <= {rs, shreg[DATA_BITS-1:1]};
            end else if (state != ST_DATA) begin
                bit_idx <= '0;
            end
        end
    end

    always_comb begin
        valid    = !fifo_empty;
        fifo_pop = valid && ready;
    end

    rs232_fifo #(
        .FIFO_LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (byte_done),
        .wdata      (shreg),
        .pop        (fifo_pop),
        .rdata      (data),
        .count      (fifo_count),
        .count_next (fifo_count_next),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            cts_n       <= 1'b1;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            cts_n       <= (fifo_count_next >= CTS_LIMIT);
            frame_error <= frame_bad;
            overrun     <= byte_done && fifo_full && !fifo_pop;
        end
    end

endmodule
